// File: rtl/axi_slave_regfile.sv
// AXI-Lite style slave with eight 32-bit registers: 0..6 read/write, 7 reads status_i.
// Optional macro AXI_SLAVE_WSTRB_EN enables per-byte write strobes.
module axi_slave_regfile #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic        axi_aclk_i,
  input  logic        axi_aresetn_i,
  input  logic [31:0] axi_araddr_i,
  input  logic        axi_arvalid_i,
  output logic        axi_arready_o,
  output logic [31:0] axi_rdata_o,
  output logic        axi_rvalid_o,
  input  logic        axi_rready_i,
  output logic        axi_rresp_o,
  input  logic [31:0] axi_awaddr_i,
  input  logic        axi_awvalid_i,
  output logic        axi_awready_o,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_wvalid_i,
  output logic        axi_wready_o,
  output logic        axi_bvalid_o,
  input  logic        axi_bready_i,
  output logic        axi_bresp_o,
  input  logic [31:0] status_i,
  output logic [31:0] ctrl_o,
  output logic        wr_stb_o,
  output logic [2:0]  wr_idx_o
);

  // state    | meaning
  // R_IDLE   | accepting a read address
  // R_DATA   | read data presented, waiting for rready
  // W_IDLE   | accepting write address and data
  // W_HAVE_A | address latched, waiting for write data
  // W_HAVE_D | data latched, waiting for write address
  // W_RESP   | write committed, response presented until bready

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;

  r_state_t r_state, r_state_nxt;
  w_state_t w_state, w_state_nxt;

  logic [31:0] regs [7];

  logic        rd_load;
  logic        rd_hit;
  logic [2:0]  rd_idx;
  logic [31:0] rd_word;

  logic        latch_a, latch_d, commit;
  logic [31:2] aw_addr_q;
  logic [31:0] wdata_q;
  logic [31:0] cm_addr;
  logic [31:0] cm_data;
  logic [2:0]  cm_idx;
  logic        cm_valid;
  logic [31:0] cm_old;
  logic [31:0] cm_wdata;

  function automatic logic in_window(input logic [31:0] a);
    return a[31:5] == BASE_ADDR[31:5];
  endfunction

  // ---------------- read channel ----------------
  always_ff @(posedge axi_aclk_i) begin
    if (axi_aresetn_i) r_state <= R_IDLE;
    else               r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt   = r_state;
    axi_arready_o = 1'b0;
    axi_rvalid_o  = 1'b0;
    rd_load       = 1'b0;
    case (r_state)
      R_IDLE: begin
        axi_arready_o = 1'b1;
        if (axi_arvalid_i) begin
          rd_load     = 1'b1;
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        axi_rvalid_o = 1'b1;
        if (axi_rready_i) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign rd_hit = in_window(axi_araddr_i);
  assign rd_idx = axi_araddr_i[4:2];

  always_comb begin
    rd_word = status_i;
    for (int i = 0; i < 7; i++) begin
      if (rd_idx == 3'(i)) rd_word = regs[i];
    end
  end

  // Sampling regs here at the same edge as a commit naturally yields the pre-write value.
  always_ff @(posedge axi_aclk_i) begin
    if (axi_aresetn_i) begin
      axi_rdata_o <= 32'd0;
      axi_rresp_o <= 1'b0;
    end else if (rd_load) begin
      axi_rdata_o <= rd_hit ? rd_word : 32'd0;
      axi_rresp_o <= rd_hit;
    end
  end

  // ---------------- write channel ----------------
  always_ff @(posedge axi_aclk_i) begin
    if (axi_aresetn_i) w_state <= W_IDLE;
    else               w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = w_state;
    axi_awready_o = 1'b0;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;
    latch_a       = 1'b0;
    latch_d       = 1'b0;
    commit        = 1'b0;
    case (w_state)
      W_IDLE: begin
        axi_awready_o = 1'b1;
        axi_wready_o  = 1'b1;
        if (axi_awvalid_i && axi_wvalid_i) begin
          commit      = 1'b1;
          w_state_nxt = W_RESP;
        end else if (axi_awvalid_i) begin
          latch_a     = 1'b1;
          w_state_nxt = W_HAVE_A;
        end else if (axi_wvalid_i) begin
          latch_d     = 1'b1;
          w_state_nxt = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        axi_wready_o = 1'b1;
        if (axi_wvalid_i) begin
          commit      = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_HAVE_D: begin
        axi_awready_o = 1'b1;
        if (axi_awvalid_i) begin
          commit      = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Commit operands come from the live bus unless that half was latched earlier.
  assign cm_addr  = (w_state == W_HAVE_A) ? {aw_addr_q, 2'b00} : axi_awaddr_i;
  assign cm_data  = (w_state == W_HAVE_D) ? wdata_q : axi_wdata_i;
  assign cm_idx   = cm_addr[4:2];
  assign cm_valid = in_window(cm_addr) && (cm_idx != 3'd7);

  always_comb begin
    cm_old = 32'd0;
    for (int i = 0; i < 7; i++) begin
      if (cm_idx == 3'(i)) cm_old = regs[i];
    end
  end

`ifdef AXI_SLAVE_WSTRB_EN
  logic [3:0] wstrb_q;
  logic [3:0] cm_strb;

  assign cm_strb = (w_state == W_HAVE_D) ? wstrb_q : axi_wstrb_i;

  always_ff @(posedge axi_aclk_i) begin
    if (axi_aresetn_i)  wstrb_q <= 4'd0;
    else if (latch_d)   wstrb_q <= axi_wstrb_i;
  end

  always_comb begin
    cm_wdata = cm_old;
    for (int b = 0; b < 4; b++) begin
      if (cm_strb[b]) cm_wdata[b*8 +: 8] = cm_data[b*8 +: 8];
    end
  end
`else
  logic [3:0] unused_strb;
  assign unused_strb = axi_wstrb_i;

  always_comb begin
    cm_wdata = cm_data;
    if (cm_old == 32'd0) cm_wdata = cm_data;
  end
`endif

  logic [5:0] unused_addr_bits;
  assign unused_addr_bits = {axi_araddr_i[1:0], axi_awaddr_i[1:0], cm_addr[1:0]};

  always_ff @(posedge axi_aclk_i) begin
    if (axi_aresetn_i) begin
      aw_addr_q <= '0;
      wdata_q   <= 32'd0;
    end else begin
      if (latch_a) aw_addr_q <= axi_awaddr_i[31:2];
      if (latch_d) wdata_q   <= axi_wdata_i;
    end
  end

  always_ff @(posedge axi_aclk_i) begin
    if (axi_aresetn_i) begin
      for (int i = 0; i < 7; i++) regs[i] <= RESET_VAL;
    end else if (commit && cm_valid) begin
      for (int i = 0; i < 7; i++) begin
        if (cm_idx == 3'(i)) regs[i] <= cm_wdata;
      end
    end
  end

  // Response and strobe are registered at the commit edge so they line up with the first bvalid cycle.
  always_ff @(posedge axi_aclk_i) begin
    if (axi_aresetn_i) begin
      axi_bresp_o <= 1'b0;
      wr_stb_o    <= 1'b0;
      wr_idx_o    <= 3'd0;
    end else begin
      wr_stb_o <= commit && cm_valid;
      if (commit) begin
        axi_bresp_o <= cm_valid;
        wr_idx_o    <= cm_idx;
      end
    end
  end

  assign ctrl_o = regs[0];

endmodule

// File: tb/tb_axi_slave_regfile.sv
// Self-checking bench for axi_slave_regfile: directed vector table, corner sequences,
// then randomized traffic against a register-array reference model.
module tb_axi_slave_regfile;

  localparam logic [31:0] BA   = 32'h2000_0000;
  localparam logic [31:0] RV   = 32'h1357_9BDF;
  localparam logic [31:0] STAT = 32'hC0FF_EE01;
`ifdef AXI_SLAVE_WSTRB_EN
  localparam logic [31:0] EXP_R2 = 32'h00BB_00DD;
`else
  localparam logic [31:0] EXP_R2 = 32'hAABB_CCDD;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, status = '0;
  logic        arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, bready = 0;
  logic [3:0]  wstrb = '0;
  logic        arready, rvalid, rresp, awready, wready, bvalid, bresp, wr_stb;
  logic [31:0] rdata, ctrl;
  logic [2:0]  wr_idx;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_regs [7];

  always #5 clk = ~clk;

  axi_slave_regfile #(.BASE_ADDR(BA), .RESET_VAL(RV)) dut (
    .axi_aclk_i(clk), .axi_aresetn_i(rst),
    .axi_araddr_i(araddr), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rdata_o(rdata), .axi_rvalid_o(rvalid), .axi_rready_i(rready), .axi_rresp_o(rresp),
    .axi_awaddr_i(awaddr), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wvalid_i(wvalid), .axi_wready_o(wready),
    .axi_bvalid_o(bvalid), .axi_bready_i(bready), .axi_bresp_o(bresp),
    .status_i(status), .ctrl_o(ctrl), .wr_stb_o(wr_stb), .wr_idx_o(wr_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 7; i++) m_regs[i] = RV;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s, output logic resp, output logic stb);
    int idx;
    idx = int'(a[4:2]);
    resp = 1'b0;
    stb  = 1'b0;
    if (a[31:5] == BA[31:5] && idx != 7) begin
      resp = 1'b1;
      stb  = 1'b1;
      for (int b = 0; b < 4; b++) begin
`ifdef AXI_SLAVE_WSTRB_EN
        if (s[b])
`endif
          m_regs[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
  endfunction

  function automatic void model_read(input logic [31:0] a, input logic [31:0] st,
                                     output logic [31:0] d, output logic resp);
    int idx;
    idx = int'(a[4:2]);
    if (a[31:5] != BA[31:5]) begin
      d = 32'd0; resp = 1'b0;
    end else begin
      d = (idx == 7) ? st : m_regs[idx];
      resp = 1'b1;
    end
  endfunction

  // mode 0: AW and W together; 1: AW first; 2: W first. gap = idle cycles between halves.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int mode, input int gap, input int bdly,
                          input logic exp_resp, input logic exp_stb);
    awaddr = a; wdata = d; wstrb = s;
    if (mode == 0) begin
      awvalid = 1; wvalid = 1;
      chk("idle_aw_w_ready", {awready, wready}, 2'b11);
      tick();
      awvalid = 0; wvalid = 0;
    end else if (mode == 1) begin
      awvalid = 1;
      chk("idle_awready", awready, 1);
      tick();
      awvalid = 0;
      chk("have_a_ready", {awready, wready}, 2'b01);
      repeat (gap) tick();
      chk("have_a_no_bvalid", bvalid, 0);
      wvalid = 1;
      tick();
      wvalid = 0;
    end else begin
      wvalid = 1;
      chk("idle_wready", wready, 1);
      tick();
      wvalid = 0;
      chk("have_d_ready", {awready, wready}, 2'b10);
      repeat (gap) tick();
      chk("have_d_no_bvalid", bvalid, 0);
      awvalid = 1;
      tick();
      awvalid = 0;
    end
    chk("bvalid_first", bvalid, 1);
    chk("bresp", bresp, exp_resp);
    chk("wr_stb_first", wr_stb, exp_stb);
    if (exp_stb) chk("wr_idx", wr_idx, a[4:2]);
    chk("resp_ready_low", {awready, wready}, 2'b00);
    for (int k = 0; k < bdly; k++) begin
      tick();
      chk("bvalid_hold", bvalid, 1);
      chk("bresp_hold", bresp, exp_resp);
      chk("wr_stb_single", wr_stb, 0);
      chk("hold_ready_low", {awready, wready}, 2'b00);
    end
    bready = 1;
    tick();
    bready = 0;
    chk("bvalid_done", bvalid, 0);
    chk("b2b_ready", {awready, wready}, 2'b11);
  endtask

  task automatic do_read(input logic [31:0] a, input int rdly,
                         input logic [31:0] exp_d, input logic exp_resp);
    araddr = a; arvalid = 1;
    chk("idle_arready", arready, 1);
    tick();
    arvalid = 0;
    chk("rvalid_lat1", rvalid, 1);
    chk("rdata", rdata, exp_d);
    chk("rresp", rresp, exp_resp);
    chk("rdata_arready_low", arready, 0);
    for (int k = 0; k < rdly; k++) begin
      araddr = $urandom;
      tick();
      chk("rvalid_hold", rvalid, 1);
      chk("rdata_hold", rdata, exp_d);
    end
    rready = 1;
    tick();
    rready = 0;
    chk("rvalid_done", rvalid, 0);
    chk("b2b_arready", arready, 1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    bit          exp_resp;
    bit          exp_stb;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r, s;
    logic [31:0] ed;
    logic        er;
    logic [31:0] old3;

    tbl[0]  = '{0, BA + 32'h00, 32'h0,          4'h0, RV,           1, 0};
    tbl[1]  = '{1, BA + 32'h04, 32'hDEADBEEF,   4'hF, 32'h0,        1, 1};
    tbl[2]  = '{0, BA + 32'h04, 32'h0,          4'h0, 32'hDEADBEEF, 1, 0};
    tbl[3]  = '{1, BA + 32'h1C, 32'hFFFFFFFF,   4'hF, 32'h0,        0, 0};
    tbl[4]  = '{1, BA + 32'h40, 32'hFFFFFFFF,   4'hF, 32'h0,        0, 0};
    tbl[5]  = '{0, BA + 32'h1C, 32'h0,          4'h0, STAT,         1, 0};
    tbl[6]  = '{0, BA + 32'h40, 32'h0,          4'h0, 32'h0,        0, 0};
    tbl[7]  = '{1, BA + 32'h08, 32'h0,          4'hF, 32'h0,        1, 1};
    tbl[8]  = '{1, BA + 32'h08, 32'hAABBCCDD,   4'h5, 32'h0,        1, 1};
    tbl[9]  = '{0, BA + 32'h08, 32'h0,          4'h0, EXP_R2,       1, 0};
    tbl[10] = '{0, BA + 32'h03, 32'h0,          4'h0, RV,           1, 0};

    model_reset();
    status = STAT;
    repeat (3) tick();
    rst = 0;
    chk("rst_ready", {arready, awready, wready}, 3'b111);
    chk("rst_valid", {rvalid, bvalid}, 2'b00);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", {rresp, bresp}, 2'b00);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_ctrl", ctrl, RV);

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].is_wr) begin
        model_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r, s);
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3, 1, i % 2,
                 tbl[i].exp_resp, tbl[i].exp_stb);
      end else begin
        do_read(tbl[i].addr, i % 2, tbl[i].exp_data, tbl[i].exp_resp);
      end
    end

    // W two cycles ahead of AW, response stalled three cycles
    model_write(BA, 32'h12345678, 4'hF, r, s);
    do_write(BA, 32'h12345678, 4'hF, 2, 1, 3, 1'b1, 1'b1);
    chk("ctrl_after_write", ctrl, 32'h12345678);

    // read sampled in the commit cycle of the same register sees the old value
    old3 = m_regs[3];
    araddr = BA + 32'h0C; arvalid = 1;
    awaddr = BA + 32'h0C; wdata = ~old3; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick();
    arvalid = 0; awvalid = 0; wvalid = 0;
    chk("rw_same_rvalid", rvalid, 1);
    chk("rw_same_old_data", rdata, old3);
    chk("rw_same_bvalid", bvalid, 1);
    rready = 1; bready = 1;
    tick();
    rready = 0; bready = 0;
    model_write(BA + 32'h0C, ~old3, 4'hF, r, s);
    do_read(BA + 32'h0C, 0, m_regs[3], 1'b1);

    // randomized traffic against the model
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a, d;
      logic [26:0] flip;
      logic [3:0]  st;
      flip = 27'($urandom);
      if (flip == 0) flip = 27'd1;
      a = {BA[31:5], 3'($urandom_range(0, 7)), 2'($urandom)};
      if ($urandom_range(0, 5) == 0) a[31:5] = a[31:5] ^ flip;
      d  = $urandom;
      st = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        model_write(a, d, st, r, s);
        do_write(a, d, st, $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), r, s);
        chk("rand_ctrl", ctrl, m_regs[0]);
      end else begin
        status = $urandom;
        model_read(a, status, ed, er);
        do_read(a, $urandom_range(0, 2), ed, er);
      end
    end

    // reset while holding an address in W_HAVE_A
    model_write(BA + 32'h08, 32'h5555AAAA, 4'hF, r, s);
    do_write(BA + 32'h08, 32'h5555AAAA, 4'hF, 0, 0, 0, r, s);
    awaddr = BA + 32'h08; awvalid = 1;
    tick();
    awvalid = 0;
    chk("pre_rst_have_a", {awready, wready}, 2'b01);
    rst = 1;
    tick();
    rst = 0;
    model_reset();
    chk("mid_rst_no_bvalid", bvalid, 0);
    chk("mid_rst_ready", {awready, wready}, 2'b11);
    chk("mid_rst_ctrl", ctrl, RV);
    tick();
    chk("mid_rst_no_bvalid2", bvalid, 0);
    do_read(BA + 32'h08, 0, RV, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_slave_regfile.md
AXI_SLAVE_REGFILE -- requirements
Module: axi_slave_regfile

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h2000_0000, 32-byte-aligned base of the register window.
REQ-002 SHALL have parameter RESET_VAL, default 32'd0, reset value of registers 0..6.
REQ-003 SHALL have these ports:
- axi_aclk_i in 1: the only clock; all logic on its rising edge.
- axi_aresetn_i in 1: synchronous, active-high reset.
- axi_araddr_i in 32: read address.
- axi_arvalid_i in 1: read address valid.
- axi_arready_o out 1: read address ready.
- axi_rdata_o out 32: read data.
- axi_rvalid_o out 1: read data valid.
- axi_rready_i in 1: master accepts read data.
- axi_rresp_o out 1: 1 = OK, 0 = error.
- axi_awaddr_i in 32: write address.
- axi_awvalid_i in 1: write address valid.
- axi_awready_o out 1: write address ready.
- axi_wdata_i in 32: write data.
- axi_wstrb_i in 4: byte strobes.
- axi_wvalid_i in 1: write data valid.
- axi_wready_o out 1: write data ready.
- axi_bvalid_o out 1: write response valid.
- axi_bready_i in 1: master accepts write response.
- axi_bresp_o out 1: 1 = OK, 0 = error.
- status_i in 32: value returned by read-only register 7.
- ctrl_o out 32: live contents of register 0.
- wr_stb_o out 1: one-cycle pulse on each committed register write.
- wr_idx_o out 3: index of the register written; valid while wr_stb_o = 1.

Function
REQ-004 SHALL decode address A as in-window iff A[31:5] == BASE_ADDR[31:5]; register index = A[4:2]; A[1:0] ignored.
REQ-005 SHALL hold registers 0..6 as read/write; register 7 SHALL read status_i and ignore writes.
REQ-006 Read FSM SHALL have states R_IDLE and R_DATA.
- R_IDLE: axi_arready_o = 1. On axi_arvalid_i, latch rdata and rresp and go to R_DATA.
- R_DATA: axi_arready_o = 0 and axi_rvalid_o = 1. Hold rdata and rresp stable until axi_rready_i, then return to R_IDLE.
- Read latency is exactly 1 cycle from the AR handshake to the first rvalid cycle.
REQ-007 Read of an out-of-window address SHALL return rdata = 32'd0 and rresp = 0.
REQ-008 Write FSM SHALL have states W_IDLE, W_HAVE_A, W_HAVE_D and W_RESP.
- W_IDLE: awready = wready = 1.
- AW and W handshaking in the same cycle: go to W_RESP.
- AW only: latch address, go to W_HAVE_A, where only wready = 1.
- W only: latch data and strobes, go to W_HAVE_D, where only awready = 1.
- The second handshake moves to W_RESP.
REQ-009 Register commit SHALL occur on the cycle the FSM enters W_RESP. wr_stb_o and wr_idx_o SHALL pulse in the cycle after the commit, coincident with the first bvalid cycle.
REQ-010 W_RESP: bvalid = 1, awready = wready = 0. Hold bresp until axi_bready_i, then return to W_IDLE.
REQ-011 Writes out-of-window or to register 7 SHALL leave all registers unchanged, SHALL give bresp = 0 and SHALL NOT pulse wr_stb_o.
REQ-012 Read and write channels SHALL operate independently. A read sampled in the same cycle as a commit to the same register SHALL return the pre-write value.
REQ-013 Back-to-back transactions SHALL be allowed: a new AR is accepted in the cycle after an R handshake, and a new AW/W in the cycle after a B handshake.

Reset
REQ-014 While axi_aresetn_i = 1 at a clock edge, both FSMs SHALL go to IDLE and registers 0..6 SHALL load RESET_VAL.
REQ-015 Output values in the cycle after reset: arready = awready = wready = 1, rvalid = bvalid = 0, rdata = 0, rresp = bresp = 0, wr_stb_o = 0, ctrl_o = RESET_VAL.
REQ-016 Reset mid-transaction SHALL abandon the transaction with no register update and no response.

Configuration
REQ-017 With macro AXI_SLAVE_WSTRB_EN defined, a commit SHALL update only the bytes whose axi_wstrb_i bit is 1. A write with wstrb = 0 SHALL give bresp = 1, change no register and still pulse wr_stb_o.
REQ-018 Without AXI_SLAVE_WSTRB_EN, axi_wstrb_i SHALL be ignored and every commit SHALL write all 32 bits.

Verification
REQ-019 Reset, then read BASE+0x00 -> rvalid 1 cycle after the AR handshake, rdata = RESET_VAL, rresp = 1.
REQ-020 AW/W in the same cycle: BASE+0x04, wdata 32'hDEADBEEF, wstrb 4'hF, bready = 1 -> bvalid next cycle with bresp = 1, wr_stb_o with wr_idx_o = 1; read back gives 32'hDEADBEEF.
REQ-021 W two cycles before AW to BASE+0x00 with wdata 32'h12345678, then bready held 0 for 3 cycles -> bvalid held 3 cycles, ctrl_o = 32'h12345678, awready = wready = 0 until the B handshake.
REQ-022 Write 32'hFFFFFFFF to BASE+0x1C and to BASE+0x40 -> bresp = 0 both times, no wr_stb_o; a read of 0x1C returns status_i; a read of 0x40 gives rresp = 0 and rdata = 0.
REQ-023 AXI_SLAVE_WSTRB_EN defined: reg2 = 32'h0, write 32'hAABBCCDD with wstrb 4'b0101 -> reg2 = 32'h00BB00DD. Undefined: same write -> reg2 = 32'hAABBCCDD.
REQ-024 Reset asserted in W_HAVE_A after an AW to BASE+0x08 -> no bvalid, reg2 = RESET_VAL, awready = 1 in the next cycle.
